id_ex_reg: RTL and testbench

- Pipeline register between the decode stage and the execute stage of the 5-stage MIPS core.
- Captures from decode:
  - the decoded instruction, PC+8 and both register-file operands;
  - the extended immediate from the immediate-extension unit;
  - the control bundle, destination register and Tnew.
- Supports three cycle actions: hold (freeze), bubble insertion (hazard stall or flush) and in-register writeback forwarding while held.
- Keeps a wrapping count of inserted bubbles for performance tests.

---
 rtl/id_ex_if.sv | 43 ++++
 rtl/id_ex_reg.sv | 82 ++++++++
 tb/tb_id_ex_reg.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// Decode-to-execute bundle for the ID/EX pipeline register: decode-side values,
// stage control, writeback forwarding source and the registered execute-side view.
interface id_ex_if #(
  parameter int CTRL_W = 16
);
  logic              hold;
  logic              bubble;
  logic [31:0]       instr_D;
  logic [31:0]       pc8_D;
  logic [31:0]       rs_val_D;
  logic [31:0]       rt_val_D;
  logic [31:0]       ime_D;
  logic [CTRL_W-1:0] ctrl_D;
  logic [4:0]        wa_D;
  logic [1:0]        tnew_D;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [31:0]       wb_data;

  logic [31:0]       instr_E;
  logic [31:0]       pc8_E;
  logic [31:0]       rs_val_E;
  logic [31:0]       rt_val_E;
  logic [31:0]       ime_E;
  logic [CTRL_W-1:0] ctrl_E;
  logic [4:0]        wa_E;
  logic [1:0]        tnew_E;
  logic              valid_E;
  logic [15:0]       bubble_cnt;

  // Pipeline control and decode side: drives the register, observes the E stage.
  modport master (
    output hold, bubble, instr_D, pc8_D, rs_val_D, rt_val_D, ime_D, ctrl_D, wa_D, tnew_D,
           wb_we, wb_addr, wb_data,
    input  instr_E, pc8_E, rs_val_E, rt_val_E, ime_E, ctrl_E, wa_E, tnew_E, valid_E, bubble_cnt
  );

  modport slave (
    input  hold, bubble, instr_D, pc8_D, rs_val_D, rt_val_D, ime_D, ctrl_D, wa_D, tnew_D,
           wb_we, wb_addr, wb_data,
    output instr_E, pc8_E, rs_val_E, rt_val_E, ime_E, ctrl_E, wa_E, tnew_E, valid_E, bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register of the 5-stage MIPS core: load, hold with writeback
// forwarding into the held operands, bubble insertion and a wrapping bubble counter.
module id_ex_reg #(
  parameter int CTRL_W = 16
) (
  input logic    clk,
  input logic    reset,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       pc8;
    logic [31:0]       rs_val;
    logic [31:0]       rt_val;
    logic [31:0]       ime;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        wa;
    logic [1:0]        tnew;
    logic              valid;
  } stage_t;

  stage_t      e_q, e_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        fwd_rs, fwd_rt;

  // A held instruction may still be waiting on a register that retires from WB
  // meanwhile; bubbles carry no operands, so they are never updated.
  assign fwd_rs = e_q.valid && bus.wb_we && (bus.wb_addr != 5'd0) &&
                  (bus.wb_addr == e_q.instr[25:21]);
  assign fwd_rt = e_q.valid && bus.wb_we && (bus.wb_addr != 5'd0) &&
                  (bus.wb_addr == e_q.instr[20:16]);

  // NOTE: every combinational output starts from a default (hold the current
  // state) so no path through the if/else chain can infer a latch.
  always_comb begin
    e_d          = e_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.hold) begin
      if (fwd_rs) e_d.rs_val = bus.wb_data;
      if (fwd_rt) e_d.rt_val = bus.wb_data;
    end else if (bus.bubble) begin
      e_d          = '0;
      e_d.pc8      = bus.pc8_D;  // kept so a later exception can still report EPC
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end else begin
      e_d.instr  = bus.instr_D;
      e_d.pc8    = bus.pc8_D;
      e_d.rs_val = bus.rs_val_D;
      e_d.rt_val = bus.rt_val_D;
      e_d.ime    = bus.ime_D;
      e_d.ctrl   = bus.ctrl_D;
      e_d.wa     = bus.wa_D;
      e_d.tnew   = bus.tnew_D;
      e_d.valid  = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q          <= '0;
      bubble_cnt_q <= '0;
    end else begin
      e_q          <= e_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.instr_E    = e_q.instr;
  assign bus.pc8_E      = e_q.pc8;
  assign bus.rs_val_E   = e_q.rs_val;
  assign bus.rt_val_E   = e_q.rt_val;
  assign bus.ime_E      = e_q.ime;
  assign bus.ctrl_E     = e_q.ctrl;
  assign bus.wa_E       = e_q.wa;
  assign bus.tnew_E     = e_q.tnew;
  assign bus.valid_E    = e_q.valid;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scenario bench for id_ex_reg: each task drives one feature, pushes the expected
// E-stage snapshot to a scoreboard queue and compares it one edge later.
module tb_id_ex_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_if #(.CTRL_W(16)) bus ();
  id_ex_reg #(.CTRL_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] ime;
    logic [15:0] ctrl;
    logic [4:0]  wa;
    logic [1:0]  tnew;
    logic        valid;
    logic [15:0] cnt;
  } snap_t;

  snap_t exp_q[$];
  int    n_eval = 0;
  int    n_fail = 0;

  function automatic snap_t sample();
    snap_t s;
    s.instr  = bus.instr_E;
    s.pc8    = bus.pc8_E;
    s.rs_val = bus.rs_val_E;
    s.rt_val = bus.rt_val_E;
    s.ime    = bus.ime_E;
    s.ctrl   = bus.ctrl_E;
    s.wa     = bus.wa_E;
    s.tnew   = bus.tnew_E;
    s.valid  = bus.valid_E;
    s.cnt    = bus.bubble_cnt;
    return s;
  endfunction

  function automatic snap_t mk(logic [31:0] instr, logic [31:0] pc8, logic [31:0] rs,
                               logic [31:0] rt, logic [31:0] ime, logic [15:0] ctrl,
                               logic [4:0] wa, logic [1:0] tnew, logic valid,
                               logic [15:0] cnt);
    snap_t s;
    s.instr = instr; s.pc8 = pc8; s.rs_val = rs; s.rt_val = rt; s.ime = ime;
    s.ctrl = ctrl; s.wa = wa; s.tnew = tnew; s.valid = valid; s.cnt = cnt;
    return s;
  endfunction

  task automatic drive_d(logic [31:0] instr, logic [31:0] pc8, logic [31:0] rs,
                         logic [31:0] rt, logic [31:0] ime, logic [15:0] ctrl,
                         logic [4:0] wa, logic [1:0] tnew);
    bus.instr_D = instr; bus.pc8_D = pc8; bus.rs_val_D = rs; bus.rt_val_D = rt;
    bus.ime_D = ime; bus.ctrl_D = ctrl; bus.wa_D = wa; bus.tnew_D = tnew;
  endtask

  task automatic set_ctl(logic rst_v, logic hold_v, logic bubble_v);
    reset = rst_v; bus.hold = hold_v; bus.bubble = bubble_v;
  endtask

  task automatic set_wb(logic we, logic [4:0] addr, logic [31:0] data);
    bus.wb_we = we; bus.wb_addr = addr; bus.wb_data = data;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t got, e;
    drive_d(32'hDEADBEEF, 32'h1234, 32'h11, 32'h22, 32'h33, 16'hFFFF, 5'd31, 2'd3);
    set_wb(1'b1, 5'd5, 32'h5555);
    set_ctl(1'b0, 1'b1, 1'b1);
    exp_q.push_back('0);
    tick();
    got = sample(); e = exp_q.pop_front(); n_eval++;
    if (got !== e) begin
      n_fail++; $display("FAIL reset: got %h expected %h", got, e);
    end
  endtask

  task automatic test_load();
    snap_t got, e;
    set_wb(1'b0, 5'd0, 32'h0);
    set_ctl(1'b1, 1'b0, 1'b0);
    drive_d(32'h3C01ABCD, 32'h00003008, 32'h11, 32'h22, 32'hABCD0000, 16'h00A5, 5'd1, 2'd2);
    exp_q.push_back(mk(32'h3C01ABCD, 32'h00003008, 32'h11, 32'h22, 32'hABCD0000,
                       16'h00A5, 5'd1, 2'd2, 1'b1, 16'd0));
    tick();
    got = sample(); e = exp_q.pop_front(); n_eval++;
    if (got !== e) begin
      n_fail++; $display("FAIL load: got %h expected %h", got, e);
    end
  endtask

  task automatic test_hold_fwd();
    snap_t got, e;
    logic [4:0]  addr_t[5] = '{5'd0, 5'd2, 5'd0, 5'd1, 5'd1};
    logic [31:0] data_t[5] = '{32'h0, 32'h99, 32'h77, 32'h66, 32'h55};
    logic        we_t[5]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] rs_t[5]   = '{32'h5, 32'h5, 32'h5, 32'h5, 32'h55};
    logic [31:0] rt_t[5]   = '{32'h7, 32'h99, 32'h99, 32'h99, 32'h99};
    // Step 0 loads add $3,$1,$2; later steps hold while decode carries junk.
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        set_ctl(1'b1, 1'b0, 1'b0);
        drive_d(32'h00221820, 32'h0000300C, 32'h5, 32'h7, 32'h00001820, 16'h0102, 5'd3, 2'd1);
      end else begin
        set_ctl(1'b1, 1'b1, 1'b0);
        drive_d(32'hFFFF0000 | i, 32'hAAAA0000, 32'hBAD, 32'hBAD, 32'hBAD, 16'hBEEF, 5'd9, 2'd3);
      end
      set_wb(we_t[i], addr_t[i], data_t[i]);
      exp_q.push_back(mk(32'h00221820, 32'h0000300C, rs_t[i], rt_t[i], 32'h00001820,
                         16'h0102, 5'd3, 2'd1, 1'b1, 16'd0));
      tick();
      got = sample(); e = exp_q.pop_front(); n_eval++;
      if (got !== e) begin
        n_fail++; $display("FAIL hold_fwd step %0d: got %h expected %h", i, got, e);
      end
    end
    // Both operands name the same register: both update together.
    set_ctl(1'b1, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'h0);
    drive_d(32'h00E73820, 32'h00003010, 32'h1, 32'h2, 32'h0, 16'h0001, 5'd7, 2'd1);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0);
    set_wb(1'b1, 5'd7, 32'hCAFE);
    exp_q.push_back(mk(32'h00E73820, 32'h00003010, 32'hCAFE, 32'hCAFE, 32'h0,
                       16'h0001, 5'd7, 2'd1, 1'b1, 16'd0));
    tick();
    got = sample(); e = exp_q.pop_front(); n_eval++;
    if (got !== e) begin
      n_fail++; $display("FAIL hold_fwd_both: got %h expected %h", got, e);
    end
    set_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_bubble();
    snap_t got, e;
    set_ctl(1'b1, 1'b0, 1'b1);
    drive_d(32'h12345678, 32'h00003010, 32'h1, 32'h2, 32'h3, 16'h00FF, 5'd4, 2'd2);
    exp_q.push_back(mk(32'h0, 32'h00003010, 32'h0, 32'h0, 32'h0, 16'h0, 5'd0, 2'd0, 1'b0, 16'd1));
    tick();
    got = sample(); e = exp_q.pop_front(); n_eval++;
    if (got !== e) begin
      n_fail++; $display("FAIL bubble: got %h expected %h", got, e);
    end
    // Hold beats bubble; a bubble's operands are never forwarded into.
    set_ctl(1'b1, 1'b1, 1'b1);
    drive_d(32'h0, 32'h00009999, 32'h0, 32'h0, 32'h0, 16'h0, 5'd0, 2'd0);
    set_wb(1'b1, 5'd0, 32'h44);
    exp_q.push_back(mk(32'h0, 32'h00003010, 32'h0, 32'h0, 32'h0, 16'h0, 5'd0, 2'd0, 1'b0, 16'd1));
    tick();
    got = sample(); e = exp_q.pop_front(); n_eval++;
    if (got !== e) begin
      n_fail++; $display("FAIL hold_over_bubble: got %h expected %h", got, e);
    end
    set_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_back_to_back();
    snap_t got, e;
    // bubble, load, bubble, load on consecutive edges
    for (int i = 0; i < 4; i++) begin
      set_ctl(1'b1, 1'b0, (i % 2) == 0);
      drive_d(32'h20000000 + i, 32'h4000 + 4 * i, 32'h100 + i, 32'h200 + i, 32'h300 + i,
              16'h0010 + 16'(i), 5'(10 + i), 2'(i));
      if ((i % 2) == 0)
        exp_q.push_back(mk(32'h0, 32'h4000 + 4 * i, 32'h0, 32'h0, 32'h0, 16'h0, 5'd0, 2'd0,
                           1'b0, 16'(2 + i / 2)));
      else
        exp_q.push_back(mk(32'h20000000 + i, 32'h4000 + 4 * i, 32'h100 + i, 32'h200 + i,
                           32'h300 + i, 16'h0010 + 16'(i), 5'(10 + i), 2'(i), 1'b1,
                           16'(2 + i / 2)));
      tick();
      got = sample(); e = exp_q.pop_front(); n_eval++;
      if (got !== e) begin
        n_fail++; $display("FAIL back_to_back step %0d: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_counter_wrap();
    snap_t got, e;
    set_ctl(1'b0, 1'b0, 1'b0);
    tick();
    set_ctl(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 65536; i++) begin
      bus.pc8_D = 32'(i);
      exp_q.push_back(mk(32'h0, 32'(i), 32'h0, 32'h0, 32'h0, 16'h0, 5'd0, 2'd0, 1'b0, 16'(i)));
      tick();
      got = sample(); e = exp_q.pop_front(); n_eval++;
      if (got !== e) begin
        n_fail++; $display("FAIL counter_wrap bubble %0d: got %h expected %h", i, got, e);
      end
    end
    n_eval++;
    if (bus.bubble_cnt !== 16'd0) begin
      n_fail++; $display("FAIL counter_wrap_final: got %h expected 0000", bus.bubble_cnt);
    end
  endtask

  task automatic test_reset_mid_hold();
    snap_t got, e;
    set_ctl(1'b1, 1'b0, 1'b1);
    tick();
    set_ctl(1'b1, 1'b0, 1'b0);
    drive_d(32'h8C450004, 32'h5008, 32'hA, 32'hB, 32'h4, 16'h1234, 5'd5, 2'd2);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0);
    tick();
    set_ctl(1'b0, 1'b1, 1'b0);
    exp_q.push_back('0);
    tick();
    got = sample(); e = exp_q.pop_front(); n_eval++;
    if (got !== e) begin
      n_fail++; $display("FAIL reset_mid_hold: got %h expected %h", got, e);
    end
    set_ctl(1'b1, 1'b0, 1'b0);
    drive_d(32'hAC660008, 32'h600C, 32'hC, 32'hD, 32'h8, 16'h4321, 5'd0, 2'd0);
    exp_q.push_back(mk(32'hAC660008, 32'h600C, 32'hC, 32'hD, 32'h8, 16'h4321, 5'd0, 2'd0,
                       1'b1, 16'd0));
    tick();
    got = sample(); e = exp_q.pop_front(); n_eval++;
    if (got !== e) begin
      n_fail++; $display("FAIL load_after_reset: got %h expected %h", got, e);
    end
  endtask

  initial begin
    set_ctl(1'b0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'h0);
    drive_d('0, '0, '0, '0, '0, '0, '0, '0);
    #2;
    test_reset();
    test_load();
    test_hold_fwd();
    test_bubble();
    test_back_to_back();
    test_reset_mid_hold();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
